// File: rtl/mcp3_reqq004_pkg.sv
// Shared MCP3 request-queue constants: source count and pointer/count width helpers.
package mcp3_reqq004_pkg;

    localparam int NUM_SRC = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full queue.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mcp3_reqq_fifo.sv
// Single-source request FIFO: registered count, occupancy flags, head data and error pulses.
module mcp3_reqq_fifo
    import mcp3_reqq004_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  ready_o,
    output logic                  nonempty_o,
    output logic                  two_plus_o,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    // Ready is decoded from the registered count only; a same-cycle pop does not open a slot.
    assign ready_o     = (cnt_q != FULL_CNT);
    assign nonempty_o  = (cnt_q != '0);
    assign two_plus_o  = (cnt_q >= CW'(2));
    assign head_o      = mem_q[rd_ptr_q];

    assign do_push     = push_i && ready_o;
    assign do_pop      = pop_i && nonempty_o;
    assign overflow_o  = push_i && !ready_o;
    assign underflow_o = pop_i && !nonempty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is plain RAM with no reset; stale content is masked by the count.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mcp3_reqq004.sv
// Four-source request queueing stage in front of the MCP3 round-robin arbiter.
module mcp3_reqq004
    import mcp3_reqq004_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic [NUM_SRC-1:0]              req_bus,
    output logic [NUM_SRC-1:0]              req_bus_2pending,
    input  logic [NUM_SRC-1:0]              req_clear,
    input  logic                            winner_valid,
    input  logic [1:0]                      winner,
    output logic                            sel_valid,
    output logic [DATA_WIDTH-1:0]           sel_data,
    output logic                            err_overflow,
    output logic                            err_underflow
);

    // Handshake: a push on source i is accepted in a cycle where src_valid[i] && src_ready[i];
    // src_valid with src_ready low is a protocol error, the payload is dropped and err_overflow sticks.
    logic [DATA_WIDTH-1:0] head [NUM_SRC];
    logic [NUM_SRC-1:0]    ovf_pulse;
    logic [NUM_SRC-1:0]    udf_pulse;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        mcp3_reqq_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clock       (clock),
            .reset_n     (reset_n),
            .push_i      (src_valid[i]),
            .push_data_i (src_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i       (req_clear[i]),
            .ready_o     (src_ready[i]),
            .nonempty_o  (req_bus[i]),
            .two_plus_o  (req_bus_2pending[i]),
            .head_o      (head[i]),
            .overflow_o  (ovf_pulse[i]),
            .underflow_o (udf_pulse[i])
        );
    end

    assign sel_valid = winner_valid;
    assign sel_data  = head[winner];

    assign ovf_d = ovf_q | (|ovf_pulse);
    assign udf_d = udf_q | (|udf_pulse);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;

endmodule
